// File: rtl/ldtu_tx_scheduler.sv
// LDTU output scheduler: sync phase, then serves serializer word requests from the
// output FIFO through a one-entry prefetch register. Optional idle counter: LDTU_TX_IDLE_CNT_EN.
module ldtu_tx_scheduler #(
  parameter int                  Nbits_32    = 32,
  parameter logic [Nbits_32-1:0] IdlePattern = 32'hEAAAAAAA,
  parameter logic [Nbits_32-1:0] SyncPattern = 32'h5A5A5A5A,
  parameter int                  SyncWords   = 16
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                word_req,
  input  logic                sync_req,
  input  logic                fifo_empty,
  input  logic [Nbits_32-1:0] fifo_rd_data,
  output logic                fifo_rd_en,
  output logic [Nbits_32-1:0] DATA_out,
  output logic                word_ack,
  output logic                sync_done,
  output logic [15:0]         idle_count
);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [7:0] SyncLast = 8'(SyncWords - 1);

  state_e              state_q, state_d;
  logic [7:0]          sync_cnt_q, sync_cnt_d;
  logic                pf_valid_q, pf_valid_d;
  logic                rd_pending_q, rd_pending_d;
  logic [Nbits_32-1:0] pf_data_q, pf_data_d;
  logic [Nbits_32-1:0] data_q, data_d;
  logic                ack_q, ack_d;

  // Only one word may be in flight or held at a time, which hides the FIFO read latency.
  assign fifo_rd_en = (state_q == ST_RUN) && !fifo_empty && !pf_valid_q && !rd_pending_q;
  assign sync_done  = (state_q == ST_RUN);
  assign DATA_out   = data_q;
  assign word_ack   = ack_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    pf_valid_d   = pf_valid_q;
    pf_data_d    = pf_data_q;
    rd_pending_d = rd_pending_q;
    data_d       = data_q;
    ack_d        = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (word_req) begin
          data_d = SyncPattern;
          ack_d  = 1'b1;
        end
        if (sync_req) begin
          sync_cnt_d = '0;
        end else if (word_req) begin
          if (sync_cnt_q == SyncLast) begin
            state_d    = ST_RUN;
            sync_cnt_d = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + 8'd1;
          end
        end
      end
      ST_RUN: begin
        if (word_req) begin
          ack_d = 1'b1;
          if (pf_valid_q) begin
            data_d     = pf_data_q;
            pf_valid_d = 1'b0;
          end else begin
            data_d = IdlePattern;
          end
        end
        // Prefetch state survives the trip through SYNC so no word is dropped.
        if (sync_req) begin
          state_d    = ST_SYNC;
          sync_cnt_d = '0;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (rd_pending_q) begin
      pf_data_d    = fifo_rd_data;
      pf_valid_d   = 1'b1;
      rd_pending_d = 1'b0;
    end
    if (fifo_rd_en) rd_pending_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      sync_cnt_q   <= '0;
      pf_valid_q   <= 1'b0;
      rd_pending_q <= 1'b0;
      pf_data_q    <= '0;
      data_q       <= IdlePattern;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_cnt_q   <= sync_cnt_d;
      pf_valid_q   <= pf_valid_d;
      rd_pending_q <= rd_pending_d;
      pf_data_q    <= pf_data_d;
      data_q       <= data_d;
      ack_q        <= ack_d;
    end
  end

`ifdef LDTU_TX_IDLE_CNT_EN
  logic [15:0] idle_cnt_q;
  logic        idle_word;

  assign idle_word  = (state_q == ST_RUN) && word_req && !pf_valid_q;
  assign idle_count = idle_cnt_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else if (idle_word && (idle_cnt_q != 16'hFFFF)) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end
`else
  assign idle_count = 16'h0000;
`endif

endmodule
